// File: rtl/vga_stream_out.sv
// VGA timing generator fed by a {R,G,B} valid/ready stream that locks on SOF at (0,0); outputs registered, 1-cycle latency.
// Backpressure: s_ready (combinational) high only to take pixels or drop stale beats; VGA_STREAM_ERRCNT_EN adds err_count.
module vga_stream_out #(
    parameter int COLOR_W  = 8,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [3*COLOR_W-1:0]   s_data,
    input  logic                   s_valid,
    input  logic                   s_sof,
    output logic                   s_ready,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK_N,
    output logic                   VGA_SYNC_N,
    output logic                   frame_start,
    output logic                   err
`ifdef VGA_STREAM_ERRCNT_EN
    ,
    output logic [15:0]            err_count
`endif
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    // One extra bit so sync-end bounds equal to a power of two still compare correctly.
    localparam logic [HW:0] H_LAST = (HW+1)'(H_TOT - 1);
    localparam logic [HW:0] H_ACT  = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0] HS_BEG = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0] HS_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0] V_LAST = (VW+1)'(V_TOT - 1);
    localparam logic [VW:0] V_ACT  = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0] VS_BEG = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0] VS_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEEK   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [HW-1:0]        r_h_cnt;
    logic [VW-1:0]        r_v_cnt;
    logic [HW:0]          w_h;
    logic [VW:0]          w_v;
    logic                 w_h_last;
    logic                 w_v_last;
    logic                 w_wrap;
    logic                 w_active;
    logic                 w_origin;
    logic                 w_hs_on;
    logic                 w_vs_on;
    logic                 w_lock;
    logic                 w_stream_act;
    logic                 w_misplaced;
    logic                 w_underflow;
    logic                 w_show;
    logic                 w_err;
    logic                 w_running;
    logic [3*COLOR_W-1:0] r_rgb;
    logic                 r_hs;
    logic                 r_vs;
    logic                 r_blank_n;
    logic                 r_fs;
    logic                 r_err;

    assign w_h          = {1'b0, r_h_cnt};
    assign w_v          = {1'b0, r_v_cnt};
    assign w_h_last     = (w_h == H_LAST);
    assign w_v_last     = (w_v == V_LAST);
    assign w_wrap       = w_h_last && w_v_last;
    assign w_active     = (w_h < H_ACT) && (w_v < V_ACT);
    assign w_origin     = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_hs_on      = (w_h >= HS_BEG) && (w_h < HS_END);
    assign w_vs_on      = (w_v >= VS_BEG) && (w_v < VS_END);
    assign w_running    = (r_state != S_IDLE);

    assign w_lock       = (r_state == S_SEEK) && w_origin && s_valid && s_sof;
    assign w_stream_act = (r_state == S_STREAM) && w_active;
    assign w_misplaced  = w_stream_act && s_valid && s_sof && !w_origin;
    assign w_underflow  = w_stream_act && !s_valid;
    assign w_show       = w_lock || (w_stream_act && s_valid && !w_misplaced);
    assign w_err        = w_underflow || w_misplaced;

    // SEEK drains stale non-SOF beats but parks an SOF until the frame origin.
    assign s_ready = (r_state == S_SEEK)   ? (s_valid && (!s_sof || w_origin)) :
                     (r_state == S_STREAM) ? (w_active && !w_misplaced) : 1'b0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (en) w_state_nxt = S_SEEK;
            S_SEEK:   if (w_wrap && !en) w_state_nxt = S_IDLE;
                      else if (w_lock) w_state_nxt = S_STREAM;
            S_STREAM: if (w_wrap && !en) w_state_nxt = S_IDLE;
                      else if (w_err) w_state_nxt = S_SEEK;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_h_cnt <= '0;
                r_v_cnt <= '0;
            end else if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb     <= '0;
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
            r_blank_n <= 1'b0;
            r_fs      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rgb     <= w_show ? s_data : '0;
            r_hs      <= (w_running && w_hs_on) ? HS_POL : ~HS_POL;
            r_vs      <= (w_running && w_vs_on) ? VS_POL : ~VS_POL;
            r_blank_n <= w_running && w_active;
            r_fs      <= w_show && w_origin;
            r_err     <= w_err;
        end
    end

`ifdef VGA_STREAM_ERRCNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if ((r_state == S_IDLE) && en) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_count = r_err_cnt;
`endif

    assign VGA_R       = r_rgb[3*COLOR_W-1 -: COLOR_W];
    assign VGA_G       = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B       = r_rgb[COLOR_W-1:0];
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign frame_start = r_fs;
    assign err         = r_err;

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out on a 8x6 raster (H 4/1/2/1, V 3/1/1/1): directed scenarios plus a random phase vs a frame-position model.
module tb_vga_stream_out;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int M_IDLE = 0, M_SEEK = 1, M_STREAM = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [23:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_sof = 1'b0;
    logic        s_ready;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic        frame_start, err;
`ifdef VGA_STREAM_ERRCNT_EN
    logic [15:0] err_count;
`endif

    vga_stream_out #(
        .COLOR_W(8),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .frame_start(frame_start), .err(err)
`ifdef VGA_STREAM_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fs     = 0;
    int n_err    = 0;

    logic [24:0] q[$];

    int          m_mode = M_IDLE;
    int          m_pos  = 0;
    logic [23:0] e_rgb  = '0;
    logic        e_hs = 1'b1, e_vs = 1'b1, e_blank = 1'b0, e_fs = 1'b0, e_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: raster position is the cycle index within the frame; rules applied per pixel.
    task automatic model_step(input logic en_i, input logic vld, input logic sof,
                              input logic [23:0] dat, output logic rdy);
        int x, y;
        bit act, org, wrap, shown, go_seek;
        x = m_pos % HT;
        y = m_pos / HT;
        act = (x < HA) && (y < VA);
        org = (m_pos == 0);
        wrap = (m_pos == FT - 1);
        rdy = 1'b0;
        shown = 1'b0;
        go_seek = 1'b0;
        e_err = 1'b0;
        if (m_mode == M_IDLE) begin
            e_rgb = '0; e_blank = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
            m_mode = en_i ? M_SEEK : M_IDLE;
            m_pos = 0;
        end else begin
            if (m_mode == M_SEEK) begin
                rdy = vld && (!sof || org);
                shown = org && vld && sof;
            end else if (act) begin
                if (!vld) begin
                    rdy = 1'b1; e_err = 1'b1; go_seek = 1'b1;
                end else if (sof && !org) begin
                    e_err = 1'b1; go_seek = 1'b1;
                end else begin
                    rdy = 1'b1; shown = 1'b1;
                end
            end
            e_rgb   = shown ? dat : 24'd0;
            e_fs    = shown && org;
            e_blank = act;
            e_hs    = !((x >= HA + HF) && (x < HA + HF + HS));
            e_vs    = !((y >= VA + VF) && (y < VA + VF + VS));
            if (wrap && !en_i)                  m_mode = M_IDLE;
            else if (m_mode == M_SEEK && shown) m_mode = M_STREAM;
            else if (go_seek)                   m_mode = M_SEEK;
            m_pos = (m_pos + 1) % FT;
        end
    endtask

    task automatic compare_outputs();
        check("VGA_R", VGA_R, e_rgb[23:16]);
        check("VGA_G", VGA_G, e_rgb[15:8]);
        check("VGA_B", VGA_B, e_rgb[7:0]);
        check("VGA_HS", VGA_HS, e_hs);
        check("VGA_VS", VGA_VS, e_vs);
        check("VGA_BLANK_N", VGA_BLANK_N, e_blank);
        check("VGA_SYNC_N", VGA_SYNC_N, 0);
        check("frame_start", frame_start, e_fs);
        check("err", err, e_err);
        if (frame_start) n_fs++;
        if (err) n_err++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, s_ready, 0);
        check({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
        check({tag, "_blank_n"}, VGA_BLANK_N, 0);
        check({tag, "_hs"}, VGA_HS, 1);
        check({tag, "_vs"}, VGA_VS, 1);
        check({tag, "_fs"}, frame_start, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Entered and left at a falling edge; outputs must drop without any rising edge.
    task automatic do_reset(input bit cmp_first);
        if (cmp_first) compare_outputs();
        rst_n = 1'b0;
        en = 1'b0;
        s_valid = 1'b0;
        s_sof = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        q.delete();
        m_mode = M_IDLE; m_pos = 0;
        e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_fs = 1'b0; e_err = 1'b0;
        n_fs = 0;
        n_err = 0;
    endtask

    task automatic cycle(input logic en_i, input logic drop);
        logic rdy;
        compare_outputs();
        en = en_i;
        if (q.size() > 0) begin
            {s_sof, s_data} = q[0];
            s_valid = !drop;
        end else begin
            s_sof = 1'b0;
            s_data = '0;
            s_valid = 1'b0;
        end
        #1;
        model_step(en_i, s_valid, s_sof, s_data, rdy);
        check("s_ready", s_ready, rdy);
        if (s_valid && rdy) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic push_beat(input logic sof);
        logic [31:0] rv;
        rv = $urandom;
        q.push_back({sof, rv[23:0]});
    endtask

    task automatic push_frame();
        for (int i = 0; i < HA * VA; i++) push_beat(i == 0);
    endtask

    task automatic end_scenario(input string tag, input int exp_fs, input int exp_err);
        compare_outputs();
        check({tag, "_frame_starts"}, n_fs, exp_fs);
        check({tag, "_errs"}, n_err, exp_err);
    endtask

    initial begin
        logic en_r;
        int   r;

        @(negedge clk);
        do_reset(1'b0);

        // Continuous stream: four locked frames, one frame_start each, no errors.
        for (int f = 0; f < 4; f++) push_frame();
        for (int c = 0; c < 1 + 4 * FT; c++) cycle(1'b1, 1'b0);
        end_scenario("stream", 4, 0);

        // Two stale beats ahead of SOF: drained in SEEK, first frame black.
        do_reset(1'b1);
        push_beat(1'b0);
        push_beat(1'b0);
        push_frame();
        push_frame();
        for (int c = 0; c < 1 + 2 * FT; c++) cycle(1'b1, 1'b0);
        end_scenario("stale", 1, 0);

        // Underflow at pixel (2,1).
        do_reset(1'b1);
        push_frame();
        push_frame();
        for (int c = 0; c < 1 + 2 * FT; c++) cycle(1'b1, c == 1 + (1 * HT + 2));
        end_scenario("underflow", 2, 1);

        // SOF arriving at pixel (1,0) is refused, then locks the next frame.
        do_reset(1'b1);
        push_beat(1'b1);
        push_frame();
        for (int c = 0; c < 1 + 2 * FT; c++) cycle(1'b1, 1'b0);
        end_scenario("misplaced_sof", 2, 1);

        // en dropped at (2,2): frame completes, then idle with syncs high.
        do_reset(1'b1);
        push_frame();
        push_frame();
        for (int c = 0; c < 1 + FT + 10; c++) cycle(c < 1 + (2 * HT + 2), 1'b0);
        end_scenario("en_drop", 1, 0);

        // Reset asserted while the raster sits at (3,1), then restart from (0,0).
        do_reset(1'b1);
        push_frame();
        for (int c = 0; c < 1 + (1 * HT + 3); c++) cycle(1'b1, 1'b0);
        check("pre_reset_blank_n", VGA_BLANK_N, 1);
        do_reset(1'b1);
        push_frame();
        for (int c = 0; c < 1 + FT; c++) cycle(1'b1, 1'b0);
        end_scenario("restart", 1, 0);

        // Random traffic: gaps, stray beats, random SOF placement, en toggling.
        do_reset(1'b1);
        en_r = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) en_r = !en_r;
            if (q.size() < 4) begin
                r = $urandom_range(0, 9);
                if (r < 8)       push_frame();
                else if (r == 8) push_beat(1'b0);
                else             push_beat($urandom_range(0, 1) == 1);
            end
            cycle(en_r, $urandom_range(0, 29) == 0);
        end
        compare_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
